// File: rtl/tlc_pkg.sv
// Shared types and helpers for the multi-phase traffic light controller.
// Lamp encoding, FSM state encoding and duration-to-timer conversion.
package tlc_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } tlc_state_t;

  // A programmed duration of 0 behaves as 1 cycle; the timer counts down to 0.
  function automatic int unsigned dur_load(input int unsigned d);
    return (d == 32'd0) ? 32'd0 : d - 32'd1;
  endfunction

endpackage

// File: rtl/tlc_next_phase.sv
// Circular priority search: first phase after active_i (own phase excluded)
// whose pending bit is set. found_o is low when no other phase is pending.
module tlc_next_phase #(
  parameter int NUM_PHASES = 4
) (
  input  logic [NUM_PHASES-1:0]         pending_i,
  input  logic [$clog2(NUM_PHASES)-1:0] active_i,
  output logic [$clog2(NUM_PHASES)-1:0] next_o,
  output logic                          found_o
);

  localparam int PW = $clog2(NUM_PHASES);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    int idx;
    next_o  = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int k = NUM_PHASES - 1; k >= 1; k--) begin
      idx = (int'(active_i) + k) % NUM_PHASES;
      if (pending_i[PW'(idx)]) begin
        next_o  = PW'(idx);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// Round-robin N-phase traffic controller: GREEN -> YELLOW -> all-red CLEAR, plus FLASH.
// Optional demand-driven phase skipping: define MULTI_PHASE_TRAFFIC_DEMAND_SKIP_EN.
module multi_phase_traffic_controller
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TIMER_W    = 8,
  parameter int FLASH_HALF = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [TIMER_W-1:0]            green_time,
  input  logic [TIMER_W-1:0]            yellow_time,
  input  logic [TIMER_W-1:0]            clear_time,
  input  logic                          flash_mode,
  input  logic [NUM_PHASES-1:0]         req,
  output logic [2*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          phase_start,
  output logic [NUM_PHASES-1:0]         req_pending
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

  tlc_state_t              state_q, state_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [PW-1:0]           active_q, active_d;
  logic [PW-1:0]           next_q, next_d;
  logic [FW-1:0]           flash_cnt_q, flash_cnt_d;
  logic                    flash_tgl_q, flash_tgl_d;
  logic                    phase_start_q, phase_start_d;
  logic [NUM_PHASES-1:0]   req_pending_q, req_pending_d;
  logic [NUM_PHASES-1:0]   clr_mask;
  logic [NUM_PHASES-1:0]   search_mask;
  logic [PW-1:0]           sel_next;
  logic                    sel_found;

`ifdef MULTI_PHASE_TRAFFIC_DEMAND_SKIP_EN
  assign search_mask = req_pending_q;
`else
  // Every phase counts as "pending", so the search degenerates to active+1.
  assign search_mask = '1;
`endif

  tlc_next_phase #(
    .NUM_PHASES (NUM_PHASES)
  ) u_next_phase (
    .pending_i (search_mask),
    .active_i  (active_q),
    .next_o    (sel_next),
    .found_o   (sel_found)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    active_d      = active_q;
    next_d        = next_q;
    flash_cnt_d   = flash_cnt_q;
    flash_tgl_d   = flash_tgl_q;
    phase_start_d = 1'b0;
    clr_mask      = '0;

    if (flash_mode) begin
      if (state_q != ST_FLASH) begin
        state_d     = ST_FLASH;
        flash_cnt_d = '0;
        flash_tgl_d = 1'b0;
      end else if (flash_cnt_q == FLASH_LAST) begin
        flash_cnt_d = '0;
        flash_tgl_d = ~flash_tgl_q;
      end else begin
        flash_cnt_d = flash_cnt_q + FW'(1);
      end
    end else if (state_q == ST_FLASH) begin
      // Leaving flash restarts the cycle so that phase 0 is served first.
      state_d     = ST_CLEAR;
      timer_d     = TIMER_W'(dur_load(32'(clear_time)));
      active_d    = LAST_PHASE;
      next_d      = '0;
      flash_cnt_d = '0;
      flash_tgl_d = 1'b0;
    end else if (enable) begin
      if (timer_q != '0) begin
        timer_d = timer_q - TIMER_W'(1);
      end else begin
        case (state_q)
          ST_CLEAR: begin
            state_d       = ST_GREEN;
            active_d      = next_q;
            timer_d       = TIMER_W'(dur_load(32'(green_time)));
            phase_start_d = 1'b1;
            clr_mask      = NUM_PHASES'(1) << next_q;
          end
          ST_GREEN: begin
            if (sel_found) begin
              state_d = ST_YELLOW;
              next_d  = sel_next;
              timer_d = TIMER_W'(dur_load(32'(yellow_time)));
            end else begin
              timer_d = TIMER_W'(dur_load(32'(green_time)));
            end
          end
          ST_YELLOW: begin
            state_d = ST_CLEAR;
            timer_d = TIMER_W'(dur_load(32'(clear_time)));
          end
          default: state_d = ST_CLEAR;
        endcase
      end
    end

    // A phase entering GREEN drops its own demand even if re-requested that cycle.
    req_pending_d = (req_pending_q | req) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_CLEAR;
      timer_q       <= '0;
      active_q      <= LAST_PHASE;
      next_q        <= '0;
      flash_cnt_q   <= '0;
      flash_tgl_q   <= 1'b0;
      phase_start_q <= 1'b0;
      req_pending_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      active_q      <= active_d;
      next_q        <= next_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_tgl_q   <= flash_tgl_d;
      phase_start_q <= phase_start_d;
      req_pending_q <= req_pending_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_lamp
      assign lights[2*gi +: 2] =
          (state_q == ST_FLASH)       ? (flash_tgl_q ? LIGHT_RED : LIGHT_YELLOW) :
          (active_q != PW'(gi))       ? LIGHT_RED :
          (state_q == ST_GREEN)       ? LIGHT_GREEN :
          (state_q == ST_YELLOW)      ? LIGHT_YELLOW : LIGHT_RED;
    end
  endgenerate

  assign active_phase = active_q;
  assign phase_start  = phase_start_q;
  assign req_pending  = req_pending_q;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Randomized bench for multi_phase_traffic_controller with a cycle-count reference model.
module tb_multi_phase_traffic_controller;

  localparam int N  = 4;
  localparam int TW = 8;
  localparam int FH = 8;
  localparam int ST_C = 0, ST_G = 1, ST_Y = 2, ST_F = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic [TW-1:0]        green_time, yellow_time, clear_time;
  logic                 flash_mode;
  logic [N-1:0]         req;
  logic [2*N-1:0]       lights;
  logic [$clog2(N)-1:0] active_phase;
  logic                 phase_start;
  logic [N-1:0]         req_pending;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: state name, cycles left in it, served phase, cycles spent in flash.
  int           m_state, m_left, m_active, m_next, m_fcnt;
  logic [N-1:0] m_pending;
  logic         m_start;

  always #5 clk = ~clk;

  multi_phase_traffic_controller #(
    .NUM_PHASES (N),
    .TIMER_W    (TW),
    .FLASH_HALF (FH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .green_time   (green_time),
    .yellow_time  (yellow_time),
    .clear_time   (clear_time),
    .flash_mode   (flash_mode),
    .req          (req),
    .lights       (lights),
    .active_phase (active_phase),
    .phase_start  (phase_start),
    .req_pending  (req_pending)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int max1(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_state = ST_C; m_left = 1; m_active = N - 1; m_next = 0;
    m_fcnt = 0; m_pending = '0; m_start = 1'b0;
  endtask

  task automatic model_step();
    logic [N-1:0] clr;
    int cand;
    bit found;
    clr = '0; cand = 0; found = 1'b0;
    m_start = 1'b0;
    if (flash_mode) begin
      if (m_state != ST_F) begin m_state = ST_F; m_fcnt = 0; end
      else m_fcnt++;
    end else if (m_state == ST_F) begin
      m_state = ST_C; m_left = max1(int'(clear_time)); m_active = N - 1; m_next = 0;
    end else if (enable) begin
      m_left--;
      if (m_left == 0) begin
        if (m_state == ST_C) begin
          m_state = ST_G; m_active = m_next; m_left = max1(int'(green_time));
          m_start = 1'b1; clr[m_active] = 1'b1;
        end else if (m_state == ST_G) begin
`ifdef MULTI_PHASE_TRAFFIC_DEMAND_SKIP_EN
          for (int k = 1; k < N; k++)
            if (!found && m_pending[(m_active + k) % N]) begin
              cand = (m_active + k) % N; found = 1'b1;
            end
`else
          cand = (m_active + 1) % N; found = 1'b1;
`endif
          if (found) begin
            m_state = ST_Y; m_next = cand; m_left = max1(int'(yellow_time));
          end else begin
            m_left = max1(int'(green_time));
          end
        end else begin
          m_state = ST_C; m_left = max1(int'(clear_time));
        end
      end
    end
    m_pending = (m_pending | req) & ~clr;
  endtask

  function automatic logic [2*N-1:0] exp_lights();
    logic [2*N-1:0] l;
    l = '0;
    for (int i = 0; i < N; i++) begin
      if (m_state == ST_F)
        l[2*i +: 2] = (((m_fcnt / FH) % 2) == 0) ? 2'b01 : 2'b00;
      else if (i == m_active && m_state == ST_G) l[2*i +: 2] = 2'b10;
      else if (i == m_active && m_state == ST_Y) l[2*i +: 2] = 2'b01;
    end
    return l;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Single compare process: every falling edge, DUT vs model plus the lamp invariant.
  initial begin
    forever begin
      int  nonred;
      bit  bad;
      @(negedge clk);
      chk("lights", 64'(lights), 64'(exp_lights()));
      chk("active_phase", 64'(active_phase), 64'(m_active));
      chk("phase_start", 64'(phase_start), 64'(m_start));
      chk("req_pending", 64'(req_pending), 64'(m_pending));
      nonred = 0; bad = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (lights[2*i +: 2] == 2'b11) bad = 1'b1;
        else if (lights[2*i +: 2] != 2'b00) nonred++;
      end
      chk("one_non_red", 64'(bad || (nonred > 1 && m_state != ST_F)), 64'(0));
    end
  end

  task automatic wait_state(input int s);
    int cyc;
    cyc = 0;
    while (m_state != s && cyc < 100) begin @(negedge clk); cyc++; end
    if (m_state != s) begin
      n_checks++; n_errors++;
      $display("FAIL wait_state: state %0d after %0d cycles, required %0d", m_state, cyc, s);
    end
  endtask

  initial begin
    int flash_left;
    reset_n = 1'b0; enable = 1'b1; flash_mode = 1'b0; req = '0;
    green_time = 8'd5; yellow_time = 8'd2; clear_time = 8'd1;
    repeat (3) @(negedge clk);
    chk("rst_lights", 64'(lights), 64'(0));
    chk("rst_active", 64'(active_phase), 64'(3));
    chk("rst_phase_start", 64'(phase_start), 64'(0));
    chk("rst_pending", 64'(req_pending), 64'(0));
    reset_n = 1'b1;

    // 5/2/1 timing after release, phase 1 requested early.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      req = (k == 2) ? N'(2) : '0;
      case (k)
        1: begin chk("lit_g0_first", 64'(lights), 64'(8'h02));
                 chk("lit_start0", 64'(phase_start), 64'(1)); end
        5: chk("lit_g0_last", 64'(lights), 64'(8'h02));
        6: chk("lit_y0_first", 64'(lights), 64'(8'h01));
        7: chk("lit_y0_last", 64'(lights), 64'(8'h01));
        8: chk("lit_clear", 64'(lights), 64'(8'h00));
        9: begin chk("lit_g1", 64'(lights), 64'(8'h08));
                 chk("lit_active1", 64'(active_phase), 64'(1)); end
        default: ;
      endcase
    end

    // Zero durations, then a mid-GREEN duration change.
    green_time = 8'd0; yellow_time = 8'd0;
    repeat (12) @(negedge clk);
    wait_state(ST_G);
    green_time = 8'd7;
    repeat (30) @(negedge clk);

    // Freeze during YELLOW while demand keeps latching.
    green_time = 8'd3; yellow_time = 8'd4;
    wait_state(ST_Y);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req = (k == 3) ? N'(4) : '0;
      @(negedge clk);
    end
    req = '0;

    // Flash requested with enable still low.
    flash_mode = 1'b1;
    @(negedge clk);
    chk("lit_flash_yellow", 64'(lights), 64'(8'h55));
    repeat (8) @(negedge clk);
    chk("lit_flash_red", 64'(lights), 64'(8'h00));
    flash_mode = 1'b0; enable = 1'b1; clear_time = 8'd1;
    @(negedge clk);
    chk("lit_post_flash_clear", 64'(lights), 64'(8'h00));
    chk("lit_post_flash_active", 64'(active_phase), 64'(3));
    @(negedge clk);
    chk("lit_post_flash_g0", 64'(lights), 64'(8'h02));
    chk("lit_post_flash_start", 64'(phase_start), 64'(1));

    // Asynchronous reset in the middle of GREEN.
    req = N'(10);
    @(negedge clk);
    req = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("lit_async_lights", 64'(lights), 64'(0));
    chk("lit_async_pending", 64'(req_pending), 64'(0));
    chk("lit_async_active", 64'(active_phase), 64'(3));
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized run.
    flash_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 9) != 0);
      req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 39) == 0) green_time  = TW'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) yellow_time = TW'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0) clear_time  = TW'($urandom_range(0, 3));
      if (flash_left > 0) begin
        flash_left--;
        flash_mode = 1'b1;
      end else begin
        flash_mode = 1'b0;
        if ($urandom_range(0, 299) == 0) flash_left = $urandom_range(1, 40);
      end
    end
    flash_mode = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_phase_traffic_controller.md
Name: multi_phase_traffic_controller

Overview:
Parametrised successor to the two-road light FSM. Sequences NUM_PHASES conflicting phases round-robin through GREEN, YELLOW and all-red CLEAR. Durations are runtime-programmable, a flash/maintenance mode is supported, and per-phase demand is latched. Sits between the intersection config registers and the lamp driver.

Parameters:
NUM_PHASES, 4, number of conflicting phases (>=2)
TIMER_W, 8, width of duration inputs and internal down-counter
FLASH_HALF, 8, cycles per half-period of flash toggle (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  high = run; low = freeze state, timer and lights
green_time  in  TIMER_W  green duration in cycles, sampled on GREEN entry
yellow_time  in  TIMER_W  yellow duration, sampled on YELLOW entry
clear_time  in  TIMER_W  all-red duration, sampled on CLEAR entry
flash_mode  in  1  level request for flash mode
req  in  NUM_PHASES  per-phase demand pulses/levels
lights  out  2*NUM_PHASES  phase i at bits [2i+1:2i]: 00 red, 01 yellow, 10 green, 11 never driven
active_phase  out  $clog2(NUM_PHASES)  phase currently served
phase_start  out  1  one-cycle pulse on the first GREEN cycle of a phase
req_pending  out  NUM_PHASES  latched demand

Behaviour:
- States: CLEAR, GREEN, YELLOW, FLASH. Encoding lives in the package. Lights are a combinational decode of registered state, active_phase and flash_phase.
- Reset (async, reset_n=0) values:
  - state=CLEAR, timer=clear_time default treated as 1, active_phase=NUM_PHASES-1.
  - All lights red; phase_start=0; req_pending=0; flash toggle=0.
- First GREEN after reset is phase 0.
- Timer loads max(duration,1)-1 on state entry. A duration of 0 acts as 1. Each state therefore lasts exactly max(duration,1) enabled cycles.
- Transitions when timer==0 and enable=1:
  - CLEAR -> GREEN of next phase; phase_start=1 that cycle.
  - GREEN -> YELLOW.
  - YELLOW -> CLEAR.
- Next phase = (active_phase+1) mod NUM_PHASES, with wrap from NUM_PHASES-1 to 0. Exception: DEMAND_SKIP_EN (see Optional Feature).
- Lighting:
  - GREEN: only active_phase is green, all others red.
  - YELLOW: only active_phase is yellow.
  - CLEAR: all red.
- Demand latching: req_pending[i] sets on req[i]=1 and clears on the cycle phase i enters GREEN. If set and clear coincide, clear wins; re-assertion the next cycle sets it again.
- enable=0: state, timer and lights hold. Demand latching continues.
- flash_mode:
  - Sampled every cycle and overrides enable. flash_mode=1 forces FLASH on the next edge from any state.
  - In FLASH, all phases show yellow and red alternately, FLASH_HALF cycles each, starting yellow.
  - flash_mode=0 in FLASH -> CLEAR with clear_time loaded; active_phase=NUM_PHASES-1, so phase 0 is served next.
- Durations changed mid-state take effect only at the next entry to that state.
- Invariant: at most one phase is non-red at any cycle. Verification asserts this.

Optional Feature:
- Macro: MULTI_PHASE_TRAFFIC_DEMAND_SKIP_EN.
- Defined, next-phase selection:
  - At GREEN expiry, next = first phase after active_phase (circular) with req_pending set.
  - If none is pending (own latch excluded), GREEN reloads green_time and stays; no YELLOW, no phase_start.
  - CLEAR exit uses the phase chosen at GREEN expiry.
- Undefined: strict round-robin; req only drives req_pending.

Decomposition:
- Package tlc_pkg:
  - light encoding constants LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN;
  - state enum tlc_state_t;
  - a function returning max(d,1)-1.
- Sub-module tlc_next_phase: combinational circular priority search, taking req_pending and active_phase and returning next index and a found flag.

Test Plan:
- Reset release with green/yellow/clear=5/2/1:
  - phase 0 green 1 cycle after release, phase_start pulses;
  - phase 0 green for 5 cycles, yellow 2, all-red 1;
  - phase 1 green at cycle 9.
- Run NUM_PHASES=4 for two full cycles: order 0,1,2,3,0. Wrap 3->0 is correct and one-non-red invariant holds.
- green_time=0, yellow_time=0: each state lasts exactly 1 cycle. Change green_time to 7 mid-GREEN: current green unaffected, next green lasts 7.
- enable low for 10 cycles during YELLOW: lights and timer frozen, req pulse still sets req_pending. Then assert flash_mode during enable low: FLASH entered next edge, alternating 8 yellow/8 red.
- Deassert flash_mode: 1 all-red cycle (clear_time=1), then phase 0 green. Assert reset_n=0 mid-GREEN: immediate all red, req_pending=0.
- With DEMAND_SKIP_EN, phase 1 green and only req[3] pulsed: 1 -> yellow -> clear -> phase 3 green. With no requests, phase 3 stays green indefinitely and phase_start does not pulse again.
